// File: rtl/vid_pkg.sv
// Framebuffer geometry shared by the prefetcher, serializer and arbiter,
// plus the prefetch FSM state type.
package vid_pkg;
  localparam int FB_BASE  = 229312;
  localparam int FB_WPL   = 32;
  localparam int FB_LINES = 768;
  localparam int FB_DEPTH = 8;
  localparam int FB_AW    = 18;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
endpackage

// File: rtl/vid_fifo.sv
// DEPTH x DW synchronous FIFO with a registered head word (rdata) and
// occupancy level; flush empties it in one cycle.
module vid_fifo #(
  parameter  int DEPTH = 8,
  parameter  int DW    = 32,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [CW-1:0] level,
  output logic          empty,
  output logic          full
);
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          pop_ok;

  assign empty  = (level == '0);
  assign full   = (level == CW'(DEPTH));
  assign pop_ok = pop && !empty;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  // rdata mirrors the head slot; it is refilled from wdata when the pushed
  // word becomes the head, otherwise from the slot behind the popped one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      rdata  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      level <= level + CW'(push) - CW'(pop_ok);
      if (push && (empty || (pop_ok && level == CW'(1))))
        rdata <= wdata;
      else if (pop_ok && level > CW'(1))
        rdata <= mem[rd_ptr + 1'b1];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && full && !flush));
endmodule

// File: rtl/vid_prefetch.sv
// Display-fetch stage: walks the framebuffer in scan order over the video
// memory port and keeps the FIFO ahead of the serializer.
module vid_prefetch
  import vid_pkg::*;
#(
  parameter int BASE  = FB_BASE,
  parameter int WPL   = FB_WPL,
  parameter int LINES = FB_LINES,
  parameter int DEPTH = FB_DEPTH,
  parameter int AW    = FB_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          vid_req,
  output logic [31:0]   vid_data,
  output logic          empty,
  output logic          underrun,
  output logic          mem_req,
  output logic [AW-1:0] mem_adr,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
);
  localparam int LW  = $clog2(LINES);
  localparam int WW  = $clog2(WPL);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CW1 = CW + 1;

  state_t          state;
  logic [LW-1:0]   line, line_n;
  logic [WW-1:0]   word, word_n;
  logic [CW-1:0]   level;
  logic [CW1-1:0]  lvl_after;
  logic            full, push, pop, room_after, more_after;

  // Lines are stored bottom-up, hence the inverted line index.
  function automatic logic [AW-1:0] adr_f(input logic [LW-1:0] l, input logic [WW-1:0] w);
    return AW'(BASE) + AW'({~l, w});
  endfunction

  assign push       = (state == REQ) && mem_ack && !frame_start;
  assign pop        = vid_req && !empty && !frame_start;
  assign word_n     = word + 1'b1;
  assign line_n     = (word == WW'(WPL - 1)) ? line + 1'b1 : line;
  assign lvl_after  = {1'b0, level} + CW1'(1) - CW1'(pop);
  assign room_after = lvl_after < CW1'(DEPTH);
  assign more_after = line_n < LW'(LINES);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_adr  <= AW'(BASE);
      line     <= '0;
      word     <= '0;
      underrun <= 1'b0;
    end else if (frame_start) begin
      line     <= '0;
      word     <= '0;
      underrun <= 1'b0;
      // An unacked request must still be completed; its data is dropped.
      if (mem_req && !mem_ack) begin
        state <= DRAIN;
      end else begin
        state   <= IDLE;
        mem_req <= 1'b0;
      end
    end else begin
      if (vid_req && empty) underrun <= 1'b1;
      unique case (state)
        IDLE: if (!full && line < LW'(LINES)) begin
          state   <= REQ;
          mem_req <= 1'b1;
          mem_adr <= adr_f(line, word);
        end
        REQ: if (mem_ack) begin
          word    <= word_n;
          line    <= line_n;
          mem_adr <= adr_f(line_n, word_n);
          if (!(room_after && more_after)) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        DRAIN: if (mem_ack) begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  vid_fifo #(.DEPTH(DEPTH), .DW(32)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (frame_start),
    .push  (push),
    .wdata (mem_rdata),
    .pop   (pop),
    .rdata (vid_data),
    .level (level),
    .empty (empty),
    .full  (full)
  );
endmodule

// File: tb/tb_vid_prefetch.sv
// Directed bench for vid_prefetch: address-tagged memory with programmable
// ack latency, scenario tasks with hand-computed expectations.
module tb_vid_prefetch;
  logic        clk = 1'b0, rst = 1'b0, frame_start = 1'b0, vid_req = 1'b0;
  logic [31:0] vid_data, mem_rdata;
  logic        empty, underrun, mem_req, mem_ack;
  logic [17:0] mem_adr;

  int          total = 0, pass = 0;
  int          lat = 1, cnt = 0;
  bit          ack_en = 1'b1;
  logic [17:0] acked[$];

  function automatic logic [31:0] tag(input logic [17:0] a);
    return 32'hC0DE0000 ^ {14'd0, a};
  endfunction

  // Word i of the frame: line i/32 stored at row 1023-line.
  function automatic logic [17:0] addr_of(input int i);
    int l = i / 32;
    int w = i % 32;
    return 18'(229312 + (1023 - l) * 32 + w);
  endfunction

  always #5 clk = ~clk;

  assign mem_ack   = mem_req && ack_en && (cnt >= lat - 1);
  assign mem_rdata = tag(mem_adr);

  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      acked.push_back(mem_adr);
      cnt <= 0;
    end else if (mem_req) cnt <= cnt + 1;
    else cnt <= 0;
  end

  vid_prefetch dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .vid_req(vid_req),
    .vid_data(vid_data), .empty(empty), .underrun(underrun),
    .mem_req(mem_req), .mem_adr(mem_adr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got=%0d exp=0", mem_req); else pass++;
    total++; if (mem_adr !== 18'd229312) $display("FAIL reset_mem_adr got=%0d exp=229312", mem_adr); else pass++;
    total++; if (empty !== 1'b1) $display("FAIL reset_empty got=%0d exp=1", empty); else pass++;
    total++; if (underrun !== 1'b0) $display("FAIL reset_underrun got=%0d exp=0", underrun); else pass++;
    total++; if (vid_data !== 32'd0) $display("FAIL reset_vid_data got=%h exp=0", vid_data); else pass++;
    rst = 1'b1;
  endtask

  task automatic test_fill;
    logic [17:0] got;
    lat = 1; ack_en = 1'b1;
    repeat (30) @(negedge clk);
    total++; if (acked.size() !== 8) $display("FAIL fill_count got=%0d exp=8", acked.size()); else pass++;
    for (int i = 0; i < 8; i++) begin
      got = (i < acked.size()) ? acked[i] : '1;
      total++; if (got !== 18'(262048 + i)) $display("FAIL fill_adr%0d got=%0d exp=%0d", i, got, 262048 + i); else pass++;
    end
    total++; if (mem_req !== 1'b0) $display("FAIL fill_req_drop got=%0d exp=0", mem_req); else pass++;
    total++; if (empty !== 1'b0) $display("FAIL fill_empty got=%0d exp=0", empty); else pass++;
    total++; if (vid_data !== tag(18'd262048)) $display("FAIL fill_head got=%h exp=%h", vid_data, tag(18'd262048)); else pass++;
  endtask

  task automatic test_stream;
    int bad = 0;
    logic [17:0] got;
    lat = 3;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      total++;
      if (empty !== 1'b0 || vid_data !== tag(addr_of(k)))
        $display("FAIL stream_word%0d got=%h empty=%0d exp=%h", k, vid_data, empty, tag(addr_of(k)));
      else pass++;
      vid_req = 1'b1;
      @(negedge clk);
      vid_req = 1'b0;
      repeat (30) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    total++; if (acked.size() !== 40) $display("FAIL stream_count got=%0d exp=40", acked.size()); else pass++;
    foreach (acked[i]) if (acked[i] !== addr_of(i)) bad++;
    total++; if (bad !== 0) $display("FAIL stream_adr_seq got=%0d bad exp=0", bad); else pass++;
    got = (acked.size() > 32) ? acked[32] : '1;
    total++; if (got !== 18'd262016) $display("FAIL stream_line_wrap got=%0d exp=262016", got); else pass++;
    total++; if (underrun !== 1'b0) $display("FAIL stream_underrun got=%0d exp=0", underrun); else pass++;
    total++; if (mem_req !== 1'b0) $display("FAIL stream_req_full got=%0d exp=0", mem_req); else pass++;
  endtask

  task automatic test_underrun;
    int npop = 0;
    logic [31:0] last = '0;
    ack_en = 1'b0;
    repeat (400) begin
      @(negedge clk);
      if (!empty) begin vid_req = 1'b1; npop++; last = vid_data; end
      else vid_req = 1'b0;
    end
    @(negedge clk); vid_req = 1'b0;
    total++; if (npop !== 8) $display("FAIL undr_pops got=%0d exp=8", npop); else pass++;
    total++; if (last !== tag(addr_of(39))) $display("FAIL undr_last got=%h exp=%h", last, tag(addr_of(39))); else pass++;
    total++; if (empty !== 1'b1) $display("FAIL undr_empty got=%0d exp=1", empty); else pass++;
    total++; if (underrun !== 1'b0) $display("FAIL undr_pre got=%0d exp=0", underrun); else pass++;
    total++; if (mem_req !== 1'b1) $display("FAIL undr_req_wait got=%0d exp=1", mem_req); else pass++;
    vid_req = 1'b1;
    @(negedge clk); vid_req = 1'b0;
    total++; if (underrun !== 1'b1) $display("FAIL undr_set got=%0d exp=1", underrun); else pass++;
    total++; if (vid_data !== tag(addr_of(39))) $display("FAIL undr_hold got=%h exp=%h", vid_data, tag(addr_of(39))); else pass++;
    total++; if (empty !== 1'b1) $display("FAIL undr_empty_post got=%0d exp=1", empty); else pass++;
  endtask

  task automatic test_drain;
    logic [17:0] got;
    frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    total++; if (underrun !== 1'b0) $display("FAIL drain_underrun_clr got=%0d exp=0", underrun); else pass++;
    total++; if (empty !== 1'b1) $display("FAIL drain_flush got=%0d exp=1", empty); else pass++;
    total++; if (mem_req !== 1'b1) $display("FAIL drain_req_hold got=%0d exp=1", mem_req); else pass++;
    total++; if (mem_adr !== 18'd262024) $display("FAIL drain_adr_hold got=%0d exp=262024", mem_adr); else pass++;
    acked.delete();
    lat = 3; ack_en = 1'b1;
    repeat (60) @(negedge clk);
    total++; if (acked.size() !== 9) $display("FAIL drain_count got=%0d exp=9", acked.size()); else pass++;
    got = (acked.size() > 1) ? acked[1] : '1;
    total++; if (got !== 18'd262048) $display("FAIL drain_restart_adr got=%0d exp=262048", got); else pass++;
    got = (acked.size() > 8) ? acked[8] : '1;
    total++; if (got !== 18'd262055) $display("FAIL drain_last_adr got=%0d exp=262055", got); else pass++;
    total++; if (vid_data !== tag(18'd262048)) $display("FAIL drain_discard got=%h exp=%h", vid_data, tag(18'd262048)); else pass++;
    total++; if (mem_req !== 1'b0) $display("FAIL drain_full got=%0d exp=0", mem_req); else pass++;
  endtask

  task automatic test_frame;
    int n = 0, bad = 0;
    logic [17:0] got;
    frame_start = 1'b1; vid_req = 1'b1;
    @(negedge clk); frame_start = 1'b0; vid_req = 1'b0;
    total++; if (empty !== 1'b1) $display("FAIL frame_flush_vs_pop got=%0d exp=1", empty); else pass++;
    acked.delete();
    lat = 1; ack_en = 1'b1;
    for (int c = 0; c < 60000 && n < 24576; c++) begin
      @(negedge clk);
      if (!empty) begin
        if (vid_data !== tag(addr_of(n))) bad++;
        n++;
        vid_req = 1'b1;
      end else vid_req = 1'b0;
    end
    @(negedge clk); vid_req = 1'b0;
    total++; if (n !== 24576) $display("FAIL frame_words got=%0d exp=24576", n); else pass++;
    total++; if (bad !== 0) $display("FAIL frame_data got=%0d bad exp=0", bad); else pass++;
    repeat (20) @(negedge clk);
    total++; if (acked.size() !== 24576) $display("FAIL frame_acks got=%0d exp=24576", acked.size()); else pass++;
    got = (acked.size() > 0) ? acked[$] : '1;
    total++; if (got !== 18'd237535) $display("FAIL frame_last_adr got=%0d exp=237535", got); else pass++;
    total++; if (empty !== 1'b1) $display("FAIL frame_end_empty got=%0d exp=1", empty); else pass++;
    total++; if (underrun !== 1'b0) $display("FAIL frame_underrun got=%0d exp=0", underrun); else pass++;
    repeat (50) @(negedge clk);
    total++; if (mem_req !== 1'b0) $display("FAIL frame_stop got=%0d exp=0", mem_req); else pass++;
    ack_en = 1'b0;
    frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    @(negedge clk);
    total++; if (mem_req !== 1'b1) $display("FAIL frame_restart_req got=%0d exp=1", mem_req); else pass++;
    total++; if (mem_adr !== 18'd262048) $display("FAIL frame_restart_adr got=%0d exp=262048", mem_adr); else pass++;
  endtask

  task automatic test_reset_mid;
    acked.delete();
    lat = 1; ack_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (acked.size() >= 5) break;
    end
    ack_en = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (acked.size() !== 5) $display("FAIL mid_level got=%0d exp=5", acked.size()); else pass++;
    total++; if (mem_req !== 1'b1 || mem_adr !== 18'd262053)
      $display("FAIL mid_req got=%0d/%0d exp=1/262053", mem_req, mem_adr); else pass++;
    total++; if (empty !== 1'b0) $display("FAIL mid_empty got=%0d exp=0", empty); else pass++;
    #2 rst = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0) $display("FAIL rstmid_mem_req got=%0d exp=0", mem_req); else pass++;
    total++; if (mem_adr !== 18'd229312) $display("FAIL rstmid_mem_adr got=%0d exp=229312", mem_adr); else pass++;
    total++; if (empty !== 1'b1) $display("FAIL rstmid_empty got=%0d exp=1", empty); else pass++;
    total++; if (underrun !== 1'b0) $display("FAIL rstmid_underrun got=%0d exp=0", underrun); else pass++;
    total++; if (vid_data !== 32'd0) $display("FAIL rstmid_vid_data got=%h exp=0", vid_data); else pass++;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (mem_req !== 1'b1 || mem_adr !== 18'd262048)
      $display("FAIL rstmid_restart got=%0d/%0d exp=1/262048", mem_req, mem_adr); else pass++;
  endtask

  initial begin
    test_reset;
    test_fill;
    test_stream;
    test_underrun;
    test_drain;
    test_frame;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
